// File: rtl/shift_ser_pkg.sv
// Shared definitions for the framed serial-to-parallel deserialiser.
// FSM encodings, counter sizing and the lane slice helper.
package shift_ser_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Bit counter width; never zero so narrow words still get a real register.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  // Low bit of lane c inside the packed multi-lane word.
  function automatic int lane_lo(input int c, input int width);
    return c * width;
  endfunction

endpackage

// File: rtl/shift_ser_lane.sv
// One serial lane: shift register plus its next-state value, so the top can
// capture the completed word on the same edge that samples the last bit.
module shift_ser_lane #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             i_serclk,
  input  logic             i_rst_n,
  input  logic             i_bit,
  input  logic             i_load_first,
  input  logic             i_shift,
  output logic [WIDTH-1:0] o_next
);

  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_next;

  // A frame drops whatever partial word was held and restarts from this bit.
  always_comb begin
    w_next = r_sr;
    if (i_load_first) begin
      if (MSB_FIRST != 0) w_next = {{(WIDTH-1){1'b0}}, i_bit};
      else                w_next = {i_bit, {(WIDTH-1){1'b0}}};
    end else if (i_shift) begin
      if (MSB_FIRST != 0) w_next = {r_sr[WIDTH-2:0], i_bit};
      else                w_next = {i_bit, r_sr[WIDTH-1:1]};
    end
  end

  always_ff @(negedge i_serclk or negedge i_rst_n) begin
    if (!i_rst_n) r_sr <= '0;
    else          r_sr <= w_next;
  end

  assign o_next = w_next;

endmodule

// File: rtl/shift_ser_in_framed.sv
// Multi-lane framed deserialiser: shared bit counter/FSM, output word register
// with valid/ready handshake, sticky overrun and sync-error flags.
module shift_ser_in_framed
  import shift_ser_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 1,
  parameter int MSB_FIRST  = 1,
  parameter int CONTINUOUS = 1
) (
  input  logic                      i_serclk,
  input  logic                      i_reset,
  input  logic [CHANNELS-1:0]       i_in,
  input  logic                      i_en,
  input  logic                      i_frame,
  input  logic                      i_out_ready,
  input  logic                      i_clr_err,
  output logic [CHANNELS*WIDTH-1:0] o_out,
  output logic                      o_out_valid,
  output logic                      o_overrun,
  output logic                      o_sync_err
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [0:0]                r_state;
  logic [CW-1:0]             r_cnt;
  logic [CHANNELS*WIDTH-1:0] r_out;
  logic                      r_valid;
  logic                      r_overrun;
  logic                      r_sync_err;

  logic                      w_start;
  logic                      w_adv;
  logic                      w_last;
  logic                      w_sync;
  logic [CHANNELS*WIDTH-1:0] w_next;

  assign w_start = i_en & i_frame;
  assign w_adv   = i_en & ~i_frame & (r_state == ST_SHIFT);
  assign w_last  = w_adv & (r_cnt == LAST_CNT);
  // count==0 in SHIFT means a word just finished, so a frame there is a clean start.
  assign w_sync  = w_start & (r_state == ST_SHIFT) & (r_cnt != '0);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    shift_ser_lane #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
    ) u_lane (
      .i_serclk     (i_serclk),
      .i_rst_n      (i_reset),
      .i_bit        (i_in[c]),
      .i_load_first (w_start),
      .i_shift      (w_adv),
      .o_next       (w_next[lane_lo(c, WIDTH) +: WIDTH])
    );
  end

  always_ff @(negedge i_serclk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_out      <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      if (w_start) begin
        r_state <= ST_SHIFT;
        r_cnt   <= CW'(1);
      end else if (w_adv) begin
        if (w_last) begin
          r_cnt   <= '0;
          r_state <= (CONTINUOUS != 0) ? ST_SHIFT : ST_IDLE;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end

      // A completing word always lands; a pending unconsumed word is lost to it.
      if (w_last) begin
        r_out   <= w_next;
        r_valid <= 1'b1;
      end else if (r_valid && i_out_ready) begin
        r_valid <= 1'b0;
      end

      r_overrun  <= (r_overrun & ~i_clr_err) | (w_last & r_valid & ~i_out_ready);
      r_sync_err <= (r_sync_err & ~i_clr_err) | w_sync;
    end
  end

  assign o_out       = r_out;
  assign o_out_valid = r_valid;
  assign o_overrun   = r_overrun;
  assign o_sync_err  = r_sync_err;

endmodule
